// File: rtl/hr_pkg.sv
// Shared types and helpers for the heart-rate measurement path.
package hr_pkg;

    localparam int HR_CNT_W = 25;
    localparam int HR_SHIFT = 18;
    localparam int HR_OUT_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        TIMEOUT = 2'd3
    } hr_state_t;

    // True when a shifted interval does not fit in an out_w-bit rate code.
    function automatic logic rate_needs_sat(input logic [31:0] shifted, input int out_w);
        return (shifted >> out_w) != 32'd0;
    endfunction

endpackage

// File: rtl/beat_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for an asynchronous sensor pulse.
module beat_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic evt
);

    logic sync_meta;
    logic sync_out;
    logic sync_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_meta <= sig_in;
            sync_out  <= sync_meta;
            sync_prev <= sync_out;
        end
    end

    // A held-high input produces exactly one event.
    assign evt = sync_out & ~sync_prev;

endmodule

// File: rtl/heart_rate_sequencer.sv
// Times beat-to-beat intervals, rejects glitches, detects pulse loss and hands out rate codes.
// Optional macro HR_AVERAGE_EN reports the mean of the last four intervals instead.
module heart_rate_sequencer
    import hr_pkg::*;
#(
    parameter int CNT_W        = HR_CNT_W,
    parameter int SHIFT        = HR_SHIFT,
    parameter int OUT_W        = HR_OUT_W,
    parameter int MIN_INTERVAL = 2**16,
    parameter int MAX_INTERVAL = 2**24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             beat_in,
    input  logic             rate_ready,
    output logic [OUT_W-1:0] rate,
    output logic             rate_valid,
    output logic             no_pulse,
    output logic             overrun,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_INTERVAL);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INTERVAL);

    hr_state_t        state;
    logic [CNT_W-1:0] count;
    logic             have_ref;
    logic             beat_evt;

    logic             long_enough;
    logic             at_max;
    logic [CNT_W-1:0] count_inc;
    logic             accept;
    logic             to_timeout;
    logic             report_now;
    logic             load;
    logic [CNT_W+1:0] report_iv;
    logic             report_ready;
    logic [31:0]      rate_shifted;
    logic [OUT_W-1:0] sat_code;
    logic [OUT_W-1:0] load_rate;

    beat_sync_edge u_beat_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_in (beat_in),
        .evt    (beat_evt)
    );

    assign long_enough = count >= MIN_CNT;
    assign at_max      = count == MAX_CNT;
    assign count_inc   = at_max ? count : count + CNT_W'(1);

    // have_ref marks an ARMED count that was started by a beat (re-arm after timeout),
    // so the interval ending in ARMED is a real measurement.
    assign accept = enable && beat_evt && long_enough &&
                    ((state == MEASURE) || ((state == ARMED) && have_ref));

    // A beat arriving on the saturating cycle wins over the timeout.
    assign to_timeout = enable && !beat_evt && at_max &&
                        ((state == ARMED) || (state == MEASURE));

`ifdef HR_AVERAGE_EN
    logic [3:0][CNT_W-1:0] hist;
    logic [CNT_W+1:0]      sum;
    logic [CNT_W+1:0]      sum_next;
    logic [2:0]            hist_cnt;
    logic                  hist_clear;

    assign sum_next     = sum + (CNT_W+2)'(count) - (CNT_W+2)'(hist[3]);
    assign report_iv    = sum_next >> 2;
    assign report_ready = hist_cnt >= 3'd3;
    assign hist_clear   = !enable || (state == IDLE) || to_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist     <= '0;
            sum      <= '0;
            hist_cnt <= '0;
        end else if (hist_clear) begin
            hist     <= '0;
            sum      <= '0;
            hist_cnt <= '0;
        end else if (accept) begin
            hist <= {hist[2:0], count};
            sum  <= sum_next;
            if (hist_cnt != 3'd4) begin
                hist_cnt <= hist_cnt + 3'd1;
            end
        end
    end
`else
    assign report_iv    = (CNT_W+2)'(count);
    assign report_ready = 1'b1;
`endif

    assign report_now   = accept && report_ready;
    assign load         = report_now || to_timeout;
    assign rate_shifted = 32'(report_iv >> SHIFT);
    assign sat_code     = rate_needs_sat(rate_shifted, OUT_W) ? '1 : rate_shifted[OUT_W-1:0];
    assign load_rate    = to_timeout ? '0 : sat_code;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            have_ref   <= 1'b0;
            rate       <= '0;
            rate_valid <= 1'b0;
            no_pulse   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rate_valid && rate_ready) begin
                rate_valid <= 1'b0;
            end

            if (!enable) begin
                state      <= IDLE;
                count      <= '0;
                have_ref   <= 1'b0;
                rate_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= ARMED;
                        count    <= '0;
                        have_ref <= 1'b0;
                    end
                    ARMED: begin
                        if (beat_evt) begin
                            if (have_ref && !long_enough) begin
                                count <= count_inc;
                            end else begin
                                state <= MEASURE;
                                count <= CNT_W'(1);
                            end
                        end else if (at_max) begin
                            state <= TIMEOUT;
                        end else begin
                            count <= count_inc;
                        end
                    end
                    MEASURE: begin
                        if (accept) begin
                            count <= CNT_W'(1);
                        end else if (to_timeout) begin
                            state <= TIMEOUT;
                        end else begin
                            count <= count_inc;
                        end
                    end
                    TIMEOUT: begin
                        if (beat_evt) begin
                            state    <= ARMED;
                            count    <= CNT_W'(1);
                            have_ref <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase

                // Latest result wins; overrun flags a pending value that was never taken.
                if (load) begin
                    rate       <= load_rate;
                    rate_valid <= 1'b1;
                    overrun    <= rate_valid && !rate_ready;
                    no_pulse   <= to_timeout;
                end
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_heart_rate_sequencer.sv
// Randomised and directed bench for heart_rate_sequencer against a behavioural model.
module tb_heart_rate_sequencer;

    localparam int SHIFT   = 2;
    localparam int MIN_IV  = 8;
    localparam int MAX_A   = 200;
    localparam int MAX_B   = 1024;
    localparam int OUT_W   = 6;
    localparam int OUT_MAX = 63;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       beat_in = 1'b0;
    logic       rate_ready = 1'b1;
    logic [5:0] rate_a, rate_b;
    logic       valid_a, valid_b, nop_a, nop_b, ovr_a, ovr_b;
    logic [1:0] st_a, st_b;

    int n_cmp = 0;
    int n_fail = 0;
    int acc_a[$];
    int acc_b[$];
    int ovr_cnt_a = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    heart_rate_sequencer #(.SHIFT(SHIFT), .OUT_W(OUT_W), .MIN_INTERVAL(MIN_IV), .MAX_INTERVAL(MAX_A)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .beat_in(beat_in), .rate_ready(rate_ready),
        .rate(rate_a), .rate_valid(valid_a), .no_pulse(nop_a), .overrun(ovr_a), .state_dbg(st_a)
    );

    heart_rate_sequencer #(.SHIFT(SHIFT), .OUT_W(OUT_W), .MIN_INTERVAL(MIN_IV), .MAX_INTERVAL(MAX_B)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .beat_in(beat_in), .rate_ready(rate_ready),
        .rate(rate_b), .rate_valid(valid_b), .no_pulse(nop_b), .overrun(ovr_b), .state_dbg(st_b)
    );

    // st: 0 idle, 1 armed, 2 measure, 3 timeout; q0..q2 are the last raw beat samples.
    typedef struct {
        int st; int count; bit have_ref;
        int rate; bit valid; bit no_pulse; bit overrun;
        int h0; int h1; int h2; int h3; int hcnt;
        bit q0; bit q1; bit q2;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_clear();
        mdl_t m;
        m.st = 0; m.count = 0; m.have_ref = 0;
        m.rate = 0; m.valid = 0; m.no_pulse = 0; m.overrun = 0;
        m.h0 = 0; m.h1 = 0; m.h2 = 0; m.h3 = 0; m.hcnt = 0;
        m.q0 = 0; m.q1 = 0; m.q2 = 0;
        return m;
    endfunction

    function automatic int sat(input int x);
        return (x > OUT_MAX) ? OUT_MAX : x;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit rst, input bit en, input bit rdy,
                                      input bit beat, input int maxv);
        mdl_t n;
        bit evt, rep, tmo, ld, clr;
        int lr, inc;
        if (rst) return mdl_clear();
        n = m;
        // A rise reaches the controller two samples after it is first seen.
        evt = m.q1 && !m.q2;
        n.q2 = m.q1; n.q1 = m.q0; n.q0 = beat;
        n.overrun = 0;
        if (m.valid && rdy) n.valid = 0;
        rep = 0; tmo = 0; ld = 0; clr = 0; lr = 0;
        inc = (m.count >= maxv) ? maxv : m.count + 1;
        if (!en) begin
            n.st = 0; n.count = 0; n.have_ref = 0; n.valid = 0; clr = 1;
        end else begin
            case (m.st)
                0: begin n.st = 1; n.count = 0; n.have_ref = 0; clr = 1; end
                1: begin
                    if (evt) begin
                        if (m.have_ref && m.count < MIN_IV) n.count = inc;
                        else begin rep = m.have_ref; n.st = 2; n.count = 1; end
                    end else if (m.count == maxv) tmo = 1;
                    else n.count = inc;
                end
                2: begin
                    if (evt && m.count >= MIN_IV) begin rep = 1; n.count = 1; end
                    else if (!evt && m.count == maxv) tmo = 1;
                    else n.count = inc;
                end
                default: if (evt) begin n.st = 1; n.count = 1; n.have_ref = 1; end
            endcase
        end
        if (rep) begin
`ifdef HR_AVERAGE_EN
            n.h3 = m.h2; n.h2 = m.h1; n.h1 = m.h0; n.h0 = m.count;
            if (n.hcnt < 4) n.hcnt = n.hcnt + 1;
            if (n.hcnt == 4) begin
                ld = 1;
                lr = sat(((n.h0 + n.h1 + n.h2 + n.h3) / 4) / (1 << SHIFT));
            end
`else
            ld = 1;
            lr = sat(m.count / (1 << SHIFT));
`endif
        end
        if (tmo) begin n.st = 3; ld = 1; lr = 0; clr = 1; end
        if (clr) begin n.h0 = 0; n.h1 = 0; n.h2 = 0; n.h3 = 0; n.hcnt = 0; end
        if (ld) begin
            n.rate = lr; n.no_pulse = tmo; n.valid = 1;
            if (m.valid && !rdy) n.overrun = 1;
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: log accepted rates, advance the models, compare every output.
    task automatic tick();
        bit take_a, take_b;
        int pend_a, pend_b;
        take_a = valid_a && rate_ready;
        take_b = valid_b && rate_ready;
        pend_a = int'(rate_a);
        pend_b = int'(rate_b);
        @(posedge clk);
        #1;
        ma = mdl_step(ma, reset, enable, rate_ready, beat_in, MAX_A);
        mb = mdl_step(mb, reset, enable, rate_ready, beat_in, MAX_B);
        if (take_a) acc_a.push_back(pend_a);
        if (take_b) acc_b.push_back(pend_b);
        if (ovr_a) ovr_cnt_a++;
        check("a.rate", int'(rate_a), ma.rate);
        check("a.rate_valid", int'(valid_a), int'(ma.valid));
        check("a.no_pulse", int'(nop_a), int'(ma.no_pulse));
        check("a.overrun", int'(ovr_a), int'(ma.overrun));
        check("a.state", int'(st_a), ma.st);
        check("b.rate", int'(rate_b), mb.rate);
        check("b.rate_valid", int'(valid_b), int'(mb.valid));
        check("b.no_pulse", int'(nop_b), int'(mb.no_pulse));
        check("b.overrun", int'(ovr_b), int'(mb.overrun));
        check("b.state", int'(st_b), mb.st);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; beat_in = 1'b0; rate_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        acc_a.delete(); acc_b.delete(); ovr_cnt_a = 0;
        enable = 1'b1;
        tick();
    endtask

    // Beats rise at the given cycle offsets (negative = unused) and stay high two cycles.
    task automatic run_sched(input int t0, input int t1, input int t2, input int t3, input int t4,
                             input int tail);
        int rises[$];
        int last;
        bit hi;
        if (t0 >= 0) rises.push_back(t0);
        if (t1 >= 0) rises.push_back(t1);
        if (t2 >= 0) rises.push_back(t2);
        if (t3 >= 0) rises.push_back(t3);
        if (t4 >= 0) rises.push_back(t4);
        last = rises[rises.size() - 1];
        for (int c = 0; c <= last + tail; c++) begin
            hi = 1'b0;
            foreach (rises[i]) if (c >= rises[i] && c < rises[i] + 2) hi = 1'b1;
            beat_in = hi;
            tick();
        end
        beat_in = 1'b0;
    endtask

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    initial begin
        int next_rise, hi_left, en_off, pick;
        ma = mdl_clear();
        mb = mdl_clear();

        do_reset();
        check("reset.rate", int'(rate_a), 0);
        check("reset.valid", int'(valid_a), 0);
        check("reset.state_armed", int'(st_a), 1);

`ifndef HR_AVERAGE_EN
        // Steady 40-cycle beats.
        run_sched(0, 40, 80, -1, -1, 20);
        check("steady.count", acc_a.size(), 2);
        check("steady.first", q_at(acc_a, 0), 10);
        check("steady.second", q_at(acc_a, 1), 10);
        check("steady.no_pulse", int'(nop_a), 0);

        // Glitch 4 cycles after a valid beat is ignored.
        do_reset();
        run_sched(0, 40, 44, 80, -1, 20);
        check("glitch.count", acc_a.size(), 2);
        check("glitch.second", q_at(acc_a, 1), 10);
`endif

        // Pulse loss, then recovery at 60-cycle beats.
        do_reset();
        repeat (250) tick();
        check("timeout.count", acc_a.size(), 1);
        check("timeout.rate0", q_at(acc_a, 0), 0);
        check("timeout.state", int'(st_a), 3);
        check("timeout.no_pulse", int'(nop_a), 1);
`ifndef HR_AVERAGE_EN
        run_sched(0, 60, 120, -1, -1, 10);
        check("recover.count", acc_a.size(), 3);
        check("recover.first", q_at(acc_a, 1), 15);
        check("recover.no_pulse", int'(nop_a), 0);

        // Back-pressure: 10 overwritten by 5.
        do_reset();
        rate_ready = 1'b0;
        run_sched(0, 40, 60, -1, -1, 5);
        check("bp.rate", int'(rate_a), 5);
        check("bp.valid", int'(valid_a), 1);
        check("bp.overrun_pulses", ovr_cnt_a, 1);
        rate_ready = 1'b1;
        tick();
        check("bp.accepted", q_at(acc_a, 0), 5);
        check("bp.valid_clear", int'(valid_a), 0);

        // Saturation on the long-timeout instance, then async reset mid-interval.
        do_reset();
        run_sched(0, 300, -1, -1, -1, 100);
        check("sat.count", acc_b.size(), 1);
        check("sat.rate", q_at(acc_b, 0), 63);
        check("sat.state_measure", int'(st_b), 2);
`else
        // Averaged: periods 40,40,48,32 give one report of 10.
        do_reset();
        run_sched(0, 40, 80, 128, 160, 10);
        check("avg.count", acc_a.size(), 1);
        check("avg.rate", q_at(acc_a, 0), 10);
        check("avg.no_pulse", int'(nop_a), 0);
        run_sched(0, 100, -1, -1, -1, 40);
`endif
        #2;
        reset = 1'b1;
        #1;
        check("async.rate", int'(rate_b), 0);
        check("async.valid", int'(valid_b), 0);
        check("async.no_pulse", int'(nop_b), 0);
        check("async.state", int'(st_b), 0);
        tick();
        reset = 1'b0;

        // Random phase: mixed periods, glitches, back-pressure, enable drops, rare resets.
        enable = 1'b1;
        next_rise = 5; hi_left = 0; en_off = 0;
        for (int c = 0; c < 6000; c++) begin
            if (c == next_rise) begin
                hi_left = $urandom_range(1, 3);
                pick = $urandom_range(0, 19);
                if (pick < 3) next_rise = c + $urandom_range(4, 7);
                else if (pick < 17) next_rise = c + $urandom_range(8, 190);
                else next_rise = c + $urandom_range(190, 320);
            end
            beat_in = (hi_left > 0);
            if (hi_left > 0) hi_left--;
            rate_ready = ($urandom_range(0, 3) != 0);
            if (en_off > 0) en_off--;
            else if ($urandom_range(0, 299) == 0) en_off = $urandom_range(1, 10);
            enable = (en_off == 0);
            reset = ($urandom_range(0, 1999) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        if (!done) begin
            n_fail++;
            $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

endmodule

// File: doc/heart_rate_sequencer.md
Name: heart_rate_sequencer

Overview:
- Controls the heartbeat-interval measurement path between the pulse sensor input and the rocking control logic.
- Synchronises and edge-detects the raw beat pulse, times beat-to-beat intervals and rejects glitches.
- Detects loss of pulse and converts each accepted interval into a 6-bit rate code.
- Delivers each rate code to the consumer over a valid/ready handshake.

Parameters:
- CNT_W, 25: interval counter width.
- SHIFT, 18: rate code = interval >> SHIFT.
- OUT_W, 6: rate code width.
- MIN_INTERVAL, 2**16: intervals shorter than this (clk cycles) are rejected as glitches.
- MAX_INTERVAL, 2**24: a count reaching this value means no pulse.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- enable  in  1  measurement enable
- beat_in  in  1  raw asynchronous heartbeat pulse
- rate_ready  in  1  consumer accepts rate
- rate  out  OUT_W  current rate code
- rate_valid  out  1  rate pending for consumer
- no_pulse  out  1  timeout condition active
- overrun  out  1  one-cycle pulse: unaccepted rate overwritten
- state_dbg  out  2  FSM state encoding

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. While reset is high, all registers are cleared: rate=0, rate_valid=0, no_pulse=0, overrun=0, count=0, state=IDLE.
- Input path: beat_in passes a 2-FF synchroniser, then a rising-edge detector. This produces beat_evt, a one-clk pulse, 3 clk edges after the beat_in rise. A held-high beat_in gives exactly one event.
- Counter: count increments every clk in ARMED and MEASURE. It saturates at MAX_INTERVAL and is loaded with 1 on every accepted beat_evt, so the captured value equals the beat period in clk cycles.
- IDLE:
  - count=0.
  - enable=1 -> ARMED.
- ARMED (waiting for the first beat, no rate yet):
  - beat_evt -> MEASURE, count<=1.
  - count==MAX_INTERVAL -> TIMEOUT.
- MEASURE, on beat_evt:
  - count<MIN_INTERVAL: event ignored; count keeps running.
  - Otherwise: interval<=count, count<=1.
  - rate<=interval>>SHIFT, saturated to all-ones when the shifted value exceeds 2**OUT_W-1.
  - rate_valid<=1 on the next cycle.
- MEASURE, count==MAX_INTERVAL -> TIMEOUT.
- TIMEOUT:
  - On entry: no_pulse=1, rate<=0, rate_valid<=1 (a single zero-rate report).
  - beat_evt -> ARMED with count<=1. The next interval is treated as the first one.
  - no_pulse clears when that first accepted interval is reported.
- enable low: from any state -> IDLE next cycle. rate and no_pulse are held; rate_valid clears.
- Handshake:
  - rate_valid stays high until a cycle with rate_valid&rate_ready, then clears next cycle.
  - rate is stable while valid, except on overwrite.
  - New result while still pending: rate is overwritten (latest wins), rate_valid stays 1, overrun pulses 1 cycle.
  - New result in the same cycle as acceptance: the old value is consumed, the new value is loaded, rate_valid stays 1, no overrun.
- Simultaneous events:
  - beat_evt on the cycle count reaches MAX_INTERVAL: the beat wins; it is accepted if count≥MIN_INTERVAL.
  - enable falling together with beat_evt: enable wins and the event is dropped.
- Reset mid-measurement aborts immediately; no partial rate is emitted.

Optional Feature:
- Macro HR_AVERAGE_EN.
- Defined:
  - A 4-entry shift register of accepted intervals plus a running sum (CNT_W+2 bits).
  - Reported rate = (sum>>2)>>SHIFT, saturated.
  - rate_valid is asserted only once 4 intervals have been collected since entering MEASURE.
  - History is cleared on TIMEOUT, IDLE and reset.
- Undefined: each accepted interval is reported directly, as described above.

Decomposition:
- Shared package hr_pkg:
  - State enum (IDLE, ARMED, MEASURE, TIMEOUT), 2 bits.
  - Default CNT_W, SHIFT, OUT_W constants.
  - Rate saturation function.
- One sub-module, beat_sync_edge: 2-FF synchroniser plus rising-edge detector, outputs beat_evt. It is reusable for other sensor inputs.

Test Plan:
- Common bench setting: SHIFT=2, MIN_INTERVAL=8, MAX_INTERVAL=200, OUT_W=6, rate_ready=1.
- Beats every 40 clk: second beat gives rate=10, rate_valid 1 cycle; third beat gives rate=10 again; no_pulse=0.
- Extra beat 4 clk after a valid beat: ignored, no rate_valid; next beat at 40 clk after the valid one gives rate=10.
- No beat for 200 clk after ARMED: state TIMEOUT, no_pulse=1, rate=0 reported once. Beats every 60 clk then resume: first interval reports rate=15 and no_pulse clears.
- Back-pressure: rate_ready=0, beats every 40 then 20 clk gives rate=10 then rate=5, overrun pulse, rate_valid held. rate_ready=1 accepts 5.
- Interval of 300 clk with MAX_INTERVAL=2**10: rate saturates to 63. Reset asserted mid-interval clears all outputs within the same cycle.
- With HR_AVERAGE_EN defined, beat periods 40,40,48,32 give the first report rate=10 after the 4th interval.
